// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter that owns the async FIFO write port.
// One IDLE arbitration cycle precedes every grant; a grant lasts up to MAX_BURST accepted words.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]           ack,
  input  logic                         wfull,
  output logic                         winc,
  output logic [WIDTH-1:0]             wdata,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   cur_id
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST) + 1;
  localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] owner, owner_nxt;
  logic [IDW-1:0] last, last_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [IDW-1:0] pick, idx;
  logic           found;

  // Handshake: req[i] is held with stable req_data until ack[i]; ack[i] means
  // the word was written into the FIFO on this clock edge (winc & ~wfull).
  assign busy   = (state == BURST);
  assign cur_id = owner;
  assign winc   = (state == BURST) && req[owner] && !wfull;

  always_comb begin
    wdata = '0;
    ack   = '0;
    if (state == BURST) wdata = req_data[int'(owner)*WIDTH +: WIDTH];
    if (winc) ack[owner] = 1'b1;
  end

  // Search starts just past the previous owner so it becomes lowest priority.
  always_comb begin
    pick  = last;
    idx   = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(last) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt = pick;
          cnt_nxt   = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (!req[owner]) begin
          last_nxt  = owner;
          state_nxt = IDLE;
        end else if (winc) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            last_nxt  = owner;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      last  <= LAST_RST;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-backed requesters, grant-level model, per-cycle compare.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ*WIDTH-1:0] req_data = '0;
  logic [NUM_REQ-1:0]       ack;
  logic                     wfull = 1'b0;
  logic                     winc;
  logic [WIDTH-1:0]         wdata;
  logic                     busy;
  logic [1:0]               cur_id;

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .wfull(wfull), .winc(winc), .wdata(wdata), .busy(busy), .cur_id(cur_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  logic [WIDTH-1:0] src_q [NUM_REQ][$];
  logic [WIDTH-1:0] exp_q[$];
  int got_q[$];
  int grant_log[$];
  int winc_cyc[$];
  int cyc = 0;
  logic [NUM_REQ-1:0] ack_s = '0;
  logic prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not seen (got none, expected one) at %0t", name, $time);
  endtask

  function automatic int rr_pick(input int last_id, input logic [NUM_REQ-1:0] r);
    for (int k = 1; k <= NUM_REQ; k++)
      if (r[(last_id + k) % NUM_REQ]) return (last_id + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic int q_at(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  function automatic logic all_empty();
    for (int i = 0; i < NUM_REQ; i++)
      if (src_q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  // Grant-level model: who holds the port and how many words it has placed.
  logic m_busy  = 1'b0;
  int   m_owner = 0;
  int   m_last  = NUM_REQ - 1;
  int   m_words = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_owner <= 0;
      m_last  <= NUM_REQ - 1;
      m_words <= 0;
    end else if (!m_busy) begin
      if (req != '0) begin
        m_owner <= rr_pick(m_last, req);
        m_words <= 0;
        m_busy  <= 1'b1;
      end
    end else if (!req[m_owner]) begin
      m_last <= m_owner;
      m_busy <= 1'b0;
    end else if (!wfull) begin
      if (m_words + 1 == MAX_BURST) begin
        m_last <= m_owner;
        m_busy <= 1'b0;
      end else begin
        m_words <= m_words + 1;
      end
    end
  end

  // Requesters: pop on ack, present next queued word.
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      req[i] = (src_q[i].size() > 0);
      if (src_q[i].size() > 0) req_data[i*WIDTH +: WIDTH] = src_q[i][0];
    end
  end

  // Compare and monitor, away from the active edge.
  initial forever begin
    logic             exp_winc;
    logic [NUM_REQ-1:0] exp_ack;
    logic [WIDTH-1:0] exp_wdata;
    @(negedge clk);
    if (chk_en) begin
      exp_winc  = m_busy && req[m_owner] && !wfull;
      exp_ack   = exp_winc ? (NUM_REQ'(1) << m_owner) : '0;
      exp_wdata = m_busy ? req_data[m_owner*WIDTH +: WIDTH] : '0;
      chk("winc", winc, exp_winc);
      chk("ack", ack, exp_ack);
      chk("wdata", wdata, exp_wdata);
      chk("busy", busy, m_busy);
      chk("cur_id", cur_id, m_owner);
      if (exp_winc && src_q[m_owner].size() > 0) exp_q.push_back(src_q[m_owner][0]);
      if (winc === 1'b1) begin
        got_q.push_back(int'(wdata));
        winc_cyc.push_back(cyc);
        if (exp_q.size() > 0) chk("fifo_word", wdata, exp_q.pop_front());
        else fail_now("fifo_word_expected");
      end
      if (busy === 1'b1 && !prev_busy) grant_log.push_back(int'(cur_id));
      prev_busy = busy;
    end
    ack_s = ack;
    cyc++;
  end

  task automatic clear_logs();
    got_q.delete();
    grant_log.delete();
    winc_cyc.delete();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(posedge clk);
      #2;
      if (all_empty() && busy === 1'b0) break;
      n++;
    end
    if (n >= budget) fail_now("drain");
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic wait_words(input int count, input string name);
    int n;
    n = 0;
    while (got_q.size() != count && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 50) fail_now(name);
  endtask

  task automatic wfull_test(input int id, input int base, input int after, input int hold);
    clear_logs();
    for (int k = 0; k < 4; k++) src_q[id].push_back(WIDTH'(base + k));
    wait_words(after, "wfull_wait");
    wfull = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_winc", winc, 0);
      chk("hold_ack", ack, 0);
      chk("hold_busy", busy, 1);
      chk("hold_owner", cur_id, id);
      @(posedge clk);
      #2;
    end
    wfull = 1'b0;
    wait_drain(60);
    chk("wfull_words", got_q.size(), 4);
    for (int k = 0; k < 4; k++) chk("wfull_word", q_at(got_q, k), base + k);
    chk("wfull_grants", grant_log.size(), 1);
    chk("wfull_owner", q_at(grant_log, 0), id);
  endtask

  initial begin
    int offs2[6];
    int offs5[3];
    int first;
    int n;
    logic pushed;
    offs2 = '{0, 1, 2, 3, 5, 6};
    offs5 = '{0, 3, 4};

    chk("pick_3_0101", rr_pick(3, 4'b0101), 0);
    chk("pick_0_1001", rr_pick(0, 4'b1001), 3);
    chk("pick_1_0011", rr_pick(1, 4'b0011), 0);
    chk("pick_2_0100", rr_pick(2, 4'b0100), 2);

    // Reset with every requester active.
    for (int i = 0; i < NUM_REQ; i++) src_q[i].push_back(WIDTH'(8'h50 + i));
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_winc", winc, 0);
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cur_id", cur_id, 0);
      chk("rst_wdata", wdata, 0);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("arb_cycle_busy", busy, 0);
    chk("arb_cycle_winc", winc, 0);
    @(negedge clk);
    chk("first_busy", busy, 1);
    chk("first_owner", cur_id, 0);
    chk("first_winc", winc, 1);
    chk("first_ack", ack, 4'b0001);
    wait_drain(100);

    // All four streaming: grants 0,1,2,3,0 with 20 writes in 24 cycles.
    clear_logs();
    for (int i = 0; i < NUM_REQ; i++)
      for (int k = 0; k < 8; k++) src_q[i].push_back(WIDTH'(i*16 + k));
    wait_drain(300);
    chk("t3_total_words", got_q.size(), 32);
    first = q_at(winc_cyc, 0);
    n = 0;
    foreach (winc_cyc[k]) if (winc_cyc[k] < first + 24) n++;
    chk("t3_winc_in_24", n, 20);
    for (int k = 0; k < 5; k++) chk("t3_grant", q_at(grant_log, k), k % 4);
    chk("t3_word4", q_at(got_q, 4), 8'h10);
    chk("t3_word16", q_at(got_q, 16), 8'h04);

    // Single requester with six words: 4 + idle + 2.
    clear_logs();
    for (int k = 0; k < 6; k++) src_q[2].push_back(WIDTH'(8'h20 + k));
    wait_drain(100);
    chk("t2_words", got_q.size(), 6);
    for (int k = 0; k < 6; k++) begin
      chk("t2_data", q_at(got_q, k), 8'h20 + k);
      chk("t2_timing", q_at(winc_cyc, k) - q_at(winc_cyc, 0), offs2[k]);
    end
    chk("t2_grants", grant_log.size(), 2);
    chk("t2_grant0", q_at(grant_log, 0), 2);
    chk("t2_grant1", q_at(grant_log, 1), 2);

    // Backpressure mid-burst, and on the last word of a burst.
    wfull_test(1, 8'hA0, 2, 3);
    wfull_test(0, 8'hB0, 3, 2);

    // Early drop by requester 3, then requester 0.
    clear_logs();
    src_q[3].push_back(8'h3A);
    src_q[0].push_back(8'h0A);
    src_q[0].push_back(8'h0B);
    wait_drain(60);
    chk("t5_grants", grant_log.size(), 2);
    chk("t5_grant0", q_at(grant_log, 0), 3);
    chk("t5_grant1", q_at(grant_log, 1), 0);
    chk("t5_w0", q_at(got_q, 0), 8'h3A);
    chk("t5_w1", q_at(got_q, 1), 8'h0A);
    chk("t5_w2", q_at(got_q, 2), 8'h0B);
    for (int k = 0; k < 3; k++)
      chk("t5_timing", q_at(winc_cyc, k) - q_at(winc_cyc, 0), offs5[k]);

    // Reset during the third word of a burst.
    clear_logs();
    pushed = 1'b0;
    for (int k = 0; k < 4; k++) src_q[2].push_back(WIDTH'(8'hC0 + k));
    n = 0;
    while (got_q.size() != 2 && n < 50) begin
      @(posedge clk);
      #2;
      if (got_q.size() == 1 && !pushed) begin
        src_q[1].push_back(8'hD0);
        src_q[1].push_back(8'hD1);
        pushed = 1'b1;
      end
      n++;
    end
    if (n >= 50) fail_now("t6_wait");
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_winc", winc, 0);
    chk("t6_rst_ack", ack, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_cur_id", cur_id, 0);
    chk("t6_rst_wdata", wdata, 0);
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    rst = 1'b0;
    wait_drain(80);
    chk("t6_grants", grant_log.size(), 3);
    chk("t6_grant_after_rst", q_at(grant_log, 1), 1);
    chk("t6_grant_last", q_at(grant_log, 2), 2);
    chk("t6_words", got_q.size(), 6);
    chk("t6_w0", q_at(got_q, 0), 8'hC0);
    chk("t6_w1", q_at(got_q, 1), 8'hC1);
    chk("t6_w2", q_at(got_q, 2), 8'hD0);
    chk("t6_w3", q_at(got_q, 3), 8'hD1);
    chk("t6_w4", q_at(got_q, 4), 8'hC2);
    chk("t6_w5", q_at(got_q, 5), 8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
